// File: rtl/led_sequencer_pkg.sv
// ============================================================================
// Module      : led_sequencer_pkg
// Description : Shared pattern-mode and bounce-direction types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

`default_nettype wire

// File: rtl/led_sequencer_if.sv
// ============================================================================
// Module      : led_sequencer_if
// Description : Control inputs and LED/TICK outputs of the LED sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_sequencer_if #(
    parameter int WIDTH = 24,
    parameter int NLED  = 5
);
    import led_sequencer_pkg::*;

    logic             EN;
    mode_t            MODE;
    logic [WIDTH-1:0] DIV;
    logic [NLED-1:0]  LED;
    logic             TICK;

    modport master (output EN, MODE, DIV, input  LED, TICK);
    modport slave  (input  EN, MODE, DIV, output LED, TICK);

endinterface

`default_nettype wire

// File: rtl/led_sequencer_tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Programmable divider flagging WRAP every DIV+1 enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int WIDTH = 24
) (
    input  wire logic             CLK,
    input  wire logic             RESETN,
    input  wire logic             EN,
    input  wire logic             CLR,
    input  wire logic [WIDTH-1:0] DIV,
    output logic                  WRAP
);

    logic [WIDTH-1:0] r_p;
    logic             w_at_term;

    // >= so that lowering DIV below the current phase wraps on the next edge
    assign w_at_term = (r_p >= DIV);
    assign WRAP      = EN & w_at_term;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_p <= '0;
        end else if (CLR) begin
            r_p <= '0;
        end else if (EN) begin
            r_p <= w_at_term ? '0 : r_p + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// Module      : led_sequencer
// Description : Prescaled LED pattern engine (count, chase, bounce, blink).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int NLED  = 5
) (
    input  wire logic       CLK,
    input  wire logic       RESETN,
    led_sequencer_if.slave  bus
);

    localparam logic [NLED-1:0] c_LED_ONE = NLED'(1);

    mode_t           r_mode_q;
    dir_t            r_dir;
    logic [NLED-1:0] r_led;
    logic            r_tick;

    dir_t            w_dir_nxt;
    logic [NLED-1:0] w_led_nxt;
    logic [NLED-1:0] w_shift;
    logic            w_mode_change;
    logic            w_wrap;
    logic            w_onehot;

    assign w_mode_change = (bus.MODE != r_mode_q);
    assign w_onehot      = (r_led != '0) && ((r_led & (r_led - NLED'(1))) == '0);

    tick_prescaler #(.WIDTH(WIDTH)) u_prescaler (
        .CLK    (CLK),
        .RESETN (RESETN),
        .EN     (bus.EN),
        .CLR    (w_mode_change),
        .DIV    (bus.DIV),
        .WRAP   (w_wrap)
    );

    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        w_shift   = '0;
        if (w_mode_change) begin
            w_dir_nxt = DIR_LEFT;
            case (bus.MODE)
                MODE_CHASE, MODE_BOUNCE: w_led_nxt = c_LED_ONE;
                default:                 w_led_nxt = '0;
            endcase
        end else if (w_wrap) begin
            case (r_mode_q)
                MODE_COUNT: w_led_nxt = r_led + NLED'(1);
                MODE_CHASE: w_led_nxt = w_onehot ? {r_led[NLED-2:0], r_led[NLED-1]} : c_LED_ONE;
                MODE_BOUNCE: begin
                    if (!w_onehot) begin
                        w_led_nxt = c_LED_ONE;
                        w_dir_nxt = DIR_LEFT;
                    end else if (r_dir == DIR_LEFT) begin
                        w_shift   = r_led << 1;
                        w_led_nxt = w_shift;
                        if (w_shift[NLED-1]) w_dir_nxt = DIR_RIGHT;
                    end else begin
                        w_shift   = r_led >> 1;
                        w_led_nxt = w_shift;
                        if (w_shift[0]) w_dir_nxt = DIR_LEFT;
                    end
                end
                // Anything other than all-ones (including stray values) goes to all-ones
                default: w_led_nxt = (r_led == '1) ? '0 : '1;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_mode_q <= MODE_COUNT;
            r_dir    <= DIR_LEFT;
            r_led    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_mode_q <= bus.MODE;
            r_dir    <= w_dir_nxt;
            r_led    <= w_led_nxt;
            r_tick   <= w_wrap & ~w_mode_change;
        end
    end

    assign bus.LED  = r_led;
    assign bus.TICK = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module      : tb_led_sequencer
// Description : Scoreboard bench; expected LED values are queued per TICK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_sequencer;
    import led_sequencer_pkg::*;

    localparam int W = 4;
    localparam int N = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    led_sequencer_if #(.WIDTH(W), .NLED(N)) bus ();

    led_sequencer #(.WIDTH(W), .NLED(N)) dut (
        .CLK    (clk),
        .RESETN (rstn),
        .bus    (bus)
    );

    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_v;
    int total    = 0;
    int bad      = 0;
    int tick_cnt = 0;
    int t0       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic push(input logic [N-1:0] v);
        exp_q.push_back(v);
    endtask

    // Monitor: every TICK must match the next queued LED value
    always @(negedge clk) begin
        if (rstn && bus.TICK) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick: got LED=%b expected no tick", bus.LED);
            end else begin
                exp_v = exp_q.pop_front();
                check("tick_led", 32'(bus.LED), 32'(exp_v));
            end
        end
    end

    initial begin
        bus.EN   = 1'b0;
        bus.MODE = MODE_COUNT;
        bus.DIV  = 4'd3;
        #2;
        check("reset_led", 32'(bus.LED), 0);
        check("reset_tick", 32'(bus.TICK), 0);

        // COUNT, DIV=3: one tick every 4 edges, LED 1..31 then 0
        step(2);
        rstn   = 1'b1;
        bus.EN = 1'b1;
        for (int i = 1; i <= 32; i++) push(N'(i % 32));
        t0 = tick_cnt;
        step(128);
        check("count_wrap_led", 32'(bus.LED), 0);
        check("count_wrap_tick", 32'(bus.TICK), 1);
        drain("count_drain");
        check("count_ticks", tick_cnt - t0, 32);

        // CHASE, DIV=0
        bus.MODE = MODE_CHASE;
        bus.DIV  = 4'd0;
        step(1);
        check("chase_init_led", 32'(bus.LED), 5'b00001);
        check("chase_init_tick", 32'(bus.TICK), 0);
        push(5'b00010); push(5'b00100); push(5'b01000); push(5'b10000); push(5'b00001);
        step(5);
        drain("chase_drain");

        // BOUNCE, DIV=0: period 8
        bus.MODE = MODE_BOUNCE;
        step(1);
        check("bounce_init_led", 32'(bus.LED), 5'b00001);
        check("bounce_init_tick", 32'(bus.TICK), 0);
        push(5'b00010); push(5'b00100); push(5'b01000); push(5'b10000);
        push(5'b01000); push(5'b00100); push(5'b00010); push(5'b00001);
        push(5'b00010);
        step(9);
        drain("bounce_drain");

        // COUNT, DIV=15: freeze at p=7 for 20 cycles, tick 9 enabled edges after resume
        bus.MODE = MODE_COUNT;
        bus.DIV  = 4'd15;
        step(1);
        check("count2_init_led", 32'(bus.LED), 0);
        step(7);
        bus.EN = 1'b0;
        t0 = tick_cnt;
        step(20);
        check("hold_led", 32'(bus.LED), 0);
        check("hold_tick", 32'(bus.TICK), 0);
        check("hold_no_ticks", tick_cnt - t0, 0);
        bus.EN = 1'b1;
        step(8);
        check("resume_8_tick", 32'(bus.TICK), 0);
        push(5'd1);
        step(1);
        check("resume_9_tick", 32'(bus.TICK), 1);
        drain("resume_drain");
        check("resume_ticks", tick_cnt - t0, 1);

        // DIV lowered below the phase: wrap on the very next edge
        step(10);
        bus.DIV = 4'd2;
        push(5'd2);
        step(1);
        check("divdrop_tick", 32'(bus.TICK), 1);
        push(5'd3);
        step(2);
        check("divdrop_p0_tick", 32'(bus.TICK), 0);
        step(1);
        check("divdrop_next_tick", 32'(bus.TICK), 1);
        drain("divdrop_drain");

        // BLINK entered on a wrap edge: wrap discarded
        bus.DIV = 4'd1;
        step(1);
        check("pre_blink_tick", 32'(bus.TICK), 0);
        bus.MODE = MODE_BLINK;
        step(1);
        check("blink_init_led", 32'(bus.LED), 0);
        check("blink_init_tick", 32'(bus.TICK), 0);
        push(5'b11111); push(5'b00000); push(5'b11111);
        step(6);
        drain("blink_drain");

        // Asynchronous reset mid-CHASE
        bus.MODE = MODE_CHASE;
        bus.DIV  = 4'd0;
        step(1);
        check("chase2_init_led", 32'(bus.LED), 5'b00001);
        push(5'b00010); push(5'b00100);
        step(2);
        drain("chase2_drain");
        check("pre_reset_led", 32'(bus.LED), 5'b00100);
        #1 rstn = 1'b0;
        #1;
        check("async_reset_led", 32'(bus.LED), 0);
        check("async_reset_tick", 32'(bus.TICK), 0);
        #1 rstn = 1'b1;
        step(1);
        check("post_reset_led", 32'(bus.LED), 5'b00001);
        check("post_reset_tick", 32'(bus.TICK), 0);
        push(5'b00010);
        step(1);
        drain("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
